vga_reg_arbiter: RTL

Owns the 16x8 display register bank: clock/date values, chrono values and flags. It shares the bank between two users. The VGA central controller gets a read-only, never-stalled port. The RTC/chrono update controller gets a read/write req/ack port. RTC writes made during active video are queued in a 4-entry FIFO and committed only during vertical blanking, so the displayed digits never tear mid-frame.

---
 rtl/vga_reg_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/vga_reg_arbiter.sv
// vga_reg_arbiter: 16x8 display register bank; VGA read port plus RTC req/ack port with blank-deferred write queue
module vga_reg_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int QDEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      Blank,
    input  logic [ADDR_W-1:0]         MemAddrIn,
    output logic [DATA_W-1:0]         MemDataOut,
    input  logic                      RtcReq,
    input  logic                      RtcWe,
    input  logic [ADDR_W-1:0]         RtcAddr,
    input  logic [DATA_W-1:0]         RtcWData,
    output logic [DATA_W-1:0]         RtcRData,
    output logic                      RtcAck,
    output logic [$clog2(QDEPTH):0]   Pending
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);
    typedef enum logic [1:0] {IDLE, ACK, WFULL} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic [ADDR_W-1:0] fa [QDEPTH];
    logic [DATA_W-1:0] fd [QDEPTH];
    logic [PW-1:0]     wp, rp, idx;
    logic              pop, can_push, wr_req, push, rd, hit;
    logic [DATA_W-1:0] fwd;
    assign pop      = Blank && Pending != '0;
    assign can_push = Pending != FULL || pop;
    assign RtcAck   = state == ACK;
    always_comb begin
        wr_req   = (state == IDLE && RtcReq && RtcWe) || state == WFULL;
        push     = wr_req && can_push;
        rd       = state == IDLE && RtcReq && !RtcWe;
        state_nx = state == ACK ? IDLE : (push || rd) ? ACK : wr_req ? WFULL : IDLE;
    end
    // scan oldest to newest so the newest matching queued write wins
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            idx = rp + k[PW-1:0];
            if (k[PW:0] < Pending && fa[idx] == RtcAddr) begin
                hit = 1'b1;
                fwd = fd[idx];
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (push) begin
            fa[wp] <= RtcAddr;
            fd[wp] <= RtcWData;
        end
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            wp         <= '0;
            rp         <= '0;
            Pending    <= '0;
            MemDataOut <= '0;
            RtcRData   <= '0;
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else begin
            state      <= state_nx;
            MemDataOut <= regs[MemAddrIn];
            Pending    <= Pending + (PW+1)'(push) - (PW+1)'(pop);
            if (rd) RtcRData <= hit ? fwd : regs[RtcAddr];
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp           <= rp + 1'b1;
                regs[fa[rp]] <= fd[rp];
            end
        end
    end
endmodule
